priority_encoder: RTL and testbench

PRIORITY_ENCODER -- requirements
Module: priority_encoder

---
 rtl/priority_encoder.sv | 59 +++++
 tb/tb_priority_encoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/priority_encoder.sv
// Registered priority encoder: samples the request vector on every rising
// clock edge and presents the index of the winning request together with a
// valid flag one cycle later. LSB_FIRST selects whether the highest or the
// lowest set index wins. Indices are zero-extended into ENC_W bits.
module priority_encoder #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ENC_W     = $clog2(WIDTH),
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    output logic [ENC_W-1:0] enc,
    output logic             valid
);

    // Reject illegal parameterisations at elaboration time.
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("priority_encoder: WIDTH must be in 2..64");
    end
    if (ENC_W < $clog2(WIDTH)) begin : g_bad_enc_w
        $error("priority_encoder: ENC_W too small to hold every request index");
    end

    logic [ENC_W-1:0] enc_next;
    logic             valid_next;

    // Combinational priority selection: scan towards the winning end so that
    // the last set bit seen is the highest-priority one.
    always_comb begin
        enc_next   = '0;
        valid_next = |req;
        if (LSB_FIRST) begin
            for (int unsigned i = WIDTH; i > 0; i--) begin
                if (req[i-1]) begin
                    enc_next = ENC_W'(i - 1);
                end
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (req[i]) begin
                    enc_next = ENC_W'(i);
                end
            end
        end
    end

    // Output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc   <= '0;
            valid <= 1'b0;
        end else begin
            enc   <= enc_next;
            valid <= valid_next;
        end
    end

endmodule

// File: tb/tb_priority_encoder.sv
// Scoreboard bench for priority_encoder: two instances (MSB-first with the
// natural encode width, LSB-first with a widened zero-extended encode) see the
// same request stream. The stimulus process pushes expected results computed
// by a shift/arithmetic reference model; a monitor pops and compares one
// result per clock after each sampling edge.
module tb_priority_encoder;

    typedef struct {
        int unsigned enc;
        bit          valid;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] enc_m;
    logic       valid_m;
    logic [3:0] enc_l;
    logic       valid_l;

    int checks = 0;
    int errors = 0;

    exp_t q_m[$];
    exp_t q_l[$];

    priority_encoder #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .enc   (enc_m),
        .valid (valid_m)
    );

    priority_encoder #(.WIDTH(8), .ENC_W(4), .LSB_FIRST(1'b1)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .enc   (enc_l),
        .valid (valid_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Floor of log2 by repeated halving; 0 for an input of 0.
    function automatic int unsigned log2_floor(input int unsigned v);
        int unsigned n = 0;
        while (v > 1) begin
            v = v / 2;
            n++;
        end
        return n;
    endfunction

    // Reference: highest set bit is floor(log2(r)); lowest set bit is the
    // log2 of r with everything but its lowest set bit cleared (r & -r).
    function automatic exp_t model(input logic [7:0] r, input bit lsb_first);
        exp_t e;
        int unsigned v = int'(r);
        e.valid = (v != 0);
        if (v == 0)
            e.enc = 0;
        else if (lsb_first)
            e.enc = log2_floor(v & (~v + 1));
        else
            e.enc = log2_floor(v);
        return e;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (req=%h)", name, act, exp, req);
        end
    endtask

    // Drive one request at the falling edge, queue its expected results, and
    // return after the rising edge that samples it. release_rst drops reset
    // in the same step so the very first edge after release is checked.
    task automatic apply(input logic [7:0] r, input bit release_rst = 1'b0);
        @(negedge clk);
        if (release_rst) rst_n = 1'b1;
        req = r;
        q_m.push_back(model(r, 1'b0));
        q_l.push_back(model(r, 1'b1));
        @(posedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " msb enc"},   int'(enc_m),   0);
        check({tag, " msb valid"}, int'(valid_m), 0);
        check({tag, " lsb enc"},   int'(enc_l),   0);
        check({tag, " lsb valid"}, int'(valid_l), 0);
    endtask

    // Monitor: one registered result per cycle, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_m.size() > 0) begin
                e = q_m.pop_front();
                check("msb enc",   int'(enc_m),   e.enc);
                check("msb valid", int'(valid_m), int'(e.valid));
            end
            if (q_l.size() > 0) begin
                e = q_l.pop_front();
                check("lsb enc",   int'(enc_l),   e.enc);
                check("lsb valid", int'(valid_l), int'(e.valid));
            end
        end
    end

    initial begin
        logic [7:0] one;
        rst_n = 1'b0;
        req   = 8'hFF;

        // Reset held with all requests active: outputs stay clear across edges.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_cleared("reset hold");
        end

        // First edge after release yields a normal result.
        apply(8'hFF, 1'b1);

        // Zero input, all ones, one-hot sweep, priority patterns.
        apply(8'h00);
        apply(8'hFF);
        for (int i = 0; i < 8; i++) begin
            one = 8'h01 << i;
            apply(one);
        end
        apply(8'b0010_1100);
        apply(8'b1000_0001);
        apply(8'b1000_0000);
        apply(8'h00);

        // Random stream with a mid-stream reset pulse.
        for (int n = 0; n < 40; n++) begin
            if (n == 20) begin
                apply(8'hA4);
                #2;
                rst_n = 1'b0;
                #1;
                check_cleared("reset assert");
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    req = 8'($urandom_range(1, 255));
                    check_cleared("reset mid");
                end
                apply(8'($urandom), 1'b1);
            end else begin
                apply(8'($urandom));
            end
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && (q_m.size() > 0 || q_l.size() > 0); k++)
            @(posedge clk);
        #2;
        checks++;
        if (q_m.size() > 0 || q_l.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d results still pending, expected 0", q_m.size(), q_l.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
